// File: rtl/microprocessor.sv
// ============================================================================
// Module   : microprocessor
// Purpose  : 24-bit load-then-run processor: captures a program word per clock
//            until HALT, then executes one instruction per clock.
// Options  : MICROPROCESSOR_LOAD_OP_EN enables opcode 0x0A (register load
//            from data memory).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microprocessor #(
   parameter int IMEM_AW = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] instruction_input,
   input  logic [6:0]  select_mem,
   output logic [23:0] output_mem_cell,
   output logic        program_done_flag
);

   localparam int IMEM_DEPTH = 1 << IMEM_AW;
   localparam logic [IMEM_AW-1:0] PTR_LAST = {IMEM_AW{1'b1}};
   localparam logic [IMEM_AW-1:0] PC_ONE   = IMEM_AW'(1);

   localparam logic [7:0] OP_HALT  = 8'h00;
   localparam logic [7:0] OP_CLR   = 8'h01;
   localparam logic [7:0] OP_LDI   = 8'h02;
   localparam logic [7:0] OP_INC   = 8'h03;
   localparam logic [7:0] OP_STORE = 8'h04;
   localparam logic [7:0] OP_MOV   = 8'h06;
   localparam logic [7:0] OP_SUBI  = 8'h09;
   localparam logic [7:0] OP_XADD  = 8'h0D;
   localparam logic [7:0] OP_BNZ   = 8'h10;
`ifdef MICROPROCESSOR_LOAD_OP_EN
   localparam logic [7:0] OP_LOAD  = 8'h0A;
`endif

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [IMEM_AW-1:0] load_ptr;
   logic [IMEM_AW-1:0] pc;
   logic [23:0]        imem [0:IMEM_DEPTH-1];
   logic [23:0]        regs [0:7];
   logic [23:0]        dmem [0:127];

   logic [23:0] instr;
   logic [7:0]  op, fa, fb;
   logic [2:0]  ia, ib;
   logic [23:0] ra, rb;

   assign instr = imem[pc];
   assign op    = instr[23:16];
   assign fa    = instr[15:8];
   assign fb    = instr[7:0];
   assign ia    = fa[2:0];
   assign ib    = fb[2:0];
   assign ra    = regs[ia];
   assign rb    = regs[ib];

   assign output_mem_cell   = dmem[select_mem];
   assign program_done_flag = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:  if (instruction_input == 24'h000000 || load_ptr == PTR_LAST) state_nxt = S_RUN;
         S_RUN:   if (op == OP_HALT) state_nxt = S_DONE;
         default: state_nxt = state;
      endcase
   end

   // Instruction memory keeps its contents across reset; writes are gated
   // while reset is asserted so an aborted load cannot corrupt word 0.
   always_ff @(posedge clk) begin
      if (reset && state == S_LOAD) begin
         imem[load_ptr] <= instruction_input;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_ptr <= '0;
         pc       <= '0;
         for (int i = 0; i < 8; i++)   regs[i] <= '0;
         for (int i = 0; i < 128; i++) dmem[i] <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               load_ptr <= load_ptr + PC_ONE;
               if (state_nxt == S_RUN) pc <= '0;
            end
            S_RUN: begin
               pc <= pc + PC_ONE;
               case (op)
                  OP_HALT:  pc <= pc;
                  OP_CLR:   for (int i = 0; i < 8; i++) regs[i] <= '0;
                  OP_LDI:   regs[ia] <= {16'b0, fb};
                  OP_INC:   regs[ia] <= ra + 24'd1;
                  OP_STORE: dmem[ra[6:0]] <= rb;
                  OP_MOV:   regs[ia] <= rb;
                  OP_SUBI:  regs[ib] <= rb - {16'b0, fa};
                  OP_XADD: begin
                     // Second write wins when A==B, leaving the sum.
                     regs[ia] <= rb;
                     regs[ib] <= ra + rb;
                  end
                  // Sign extension is irrelevant: the PC wraps modulo its width.
                  OP_BNZ:   if (rb != 24'd0) pc <= pc + fa[IMEM_AW-1:0];
`ifdef MICROPROCESSOR_LOAD_OP_EN
                  OP_LOAD:  regs[ia] <= dmem[rb[6:0]];
`endif
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_microprocessor.sv
// ============================================================================
// Module   : tb_microprocessor
// Purpose  : Self-checking bench for microprocessor using an instruction-level
//            interpreter as the reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microprocessor;

   logic        clk;
   logic        reset;
   logic [23:0] instruction_input;
   logic [6:0]  select_mem;
   logic [23:0] output_mem_cell;
   logic        program_done_flag;

   microprocessor #(.IMEM_AW(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .instruction_input (instruction_input),
      .select_mem        (select_mem),
      .output_mem_cell   (output_mem_cell),
      .program_done_flag (program_done_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: architectural state of an ISA interpreter.
   logic [23:0] m_imem [32];
   logic [23:0] m_reg  [8];
   logic [23:0] m_dmem [128];
   int          m_pc;
   bit          m_done;
   logic [23:0] prog [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_reg[i])  m_reg[i]  = '0;
      foreach (m_dmem[i]) m_dmem[i] = '0;
      m_pc   = 0;
      m_done = 0;
   endtask

   task automatic model_step();
      logic [23:0] w, ra, rb;
      logic [7:0]  op, a, b;
      int          nxt;
      w  = m_imem[m_pc];
      op = w[23:16];
      a  = w[15:8];
      b  = w[7:0];
      ra = m_reg[a[2:0]];
      rb = m_reg[b[2:0]];
      nxt = (m_pc + 1) % 32;
      case (op)
         8'h00: begin m_done = 1; nxt = m_pc; end
         8'h01: foreach (m_reg[i]) m_reg[i] = '0;
         8'h02: m_reg[a[2:0]] = {16'h0, b};
         8'h03: m_reg[a[2:0]] = ra + 1;
         8'h04: m_dmem[ra[6:0]] = rb;
         8'h06: m_reg[a[2:0]] = rb;
         8'h09: m_reg[b[2:0]] = rb - a;
         8'h0D: begin m_reg[a[2:0]] = rb; m_reg[b[2:0]] = ra + rb; end
         8'h10: if (rb != 0) nxt = (m_pc + int'($signed(a))) & 31;
`ifdef MICROPROCESSOR_LOAD_OP_EN
         8'h0A: m_reg[a[2:0]] = m_dmem[rb[6:0]];
`endif
         default: ;
      endcase
      m_pc = nxt;
   endtask

   task automatic do_reset();
      logic [6:0] r;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      #2;
      check("rst_flag", program_done_flag, 1'b0);
      r = 7'($urandom);
      foreach (r[i]) ;
      select_mem = 7'd0;   #1; check("rst_mem0",   output_mem_cell, 24'd0);
      select_mem = 7'd40;  #1; check("rst_mem40",  output_mem_cell, 24'd0);
      select_mem = 7'd127; #1; check("rst_mem127", output_mem_cell, 24'd0);
      select_mem = r;      #1; check("rst_memrnd", output_mem_cell, 24'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic load_prog();
      int ptr = 0;
      foreach (prog[i]) begin
         instruction_input = prog[i];
         @(posedge clk); #1;
         m_imem[ptr] = prog[i];
         if (prog[i] == 24'h0 || ptr == 31) break;
         ptr++;
      end
      instruction_input = 24'h123456;
      check("load_flag", program_done_flag, 1'b0);
   endtask

   task automatic run_prog(input int budget, input bit expect_halt);
      for (int c = 0; c < budget && !m_done; c++) begin
         select_mem = ($urandom_range(0, 3) == 0) ? 7'd40 : 7'($urandom);
         @(posedge clk); #1;
         model_step();
         check("run_flag", program_done_flag, m_done);
         check("run_mem", output_mem_cell, m_dmem[select_mem]);
      end
      check("halt_state", program_done_flag, expect_halt);
      if (expect_halt) begin
         repeat (2) @(posedge clk);
         #1;
         check("done_hold", program_done_flag, 1'b1);
         for (int i = 0; i < 128; i++) begin
            select_mem = 7'(i);
            #1;
            check("sweep", output_mem_cell, m_dmem[i]);
         end
      end
   endtask

   task automatic set_fib();
      prog = '{24'h010000, 24'h020004, 24'h030100, 24'h090100, 24'h060601,
               24'h0D0201, 24'h10FD00, 24'h020328, 24'h040306, 24'h000000};
   endtask

   task automatic gen_random(input int len);
      logic [7:0] ops [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h09, 8'h0D, 8'h0A, 8'h3F};
      prog.delete();
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 7) == 0)
            prog.push_back({8'h10, 8'($urandom_range(1, len - i)), 8'($urandom)});
         else
            prog.push_back({ops[$urandom_range(0, 8)], 8'($urandom), 8'($urandom)});
      end
      prog.push_back(24'h0);
   endtask

   initial begin
      reset = 1'b1;
      instruction_input = '0;
      select_mem = '0;
      foreach (m_imem[i]) m_imem[i] = '0;

      do_reset();
      set_fib();
      load_prog();
      run_prog(40, 1'b1);
      select_mem = 7'd40; #1;
      check("fib40", output_mem_cell, 24'd3);

      do_reset();
      prog = '{24'h020100, 24'h090101, 24'h020205, 24'h040201, 24'h000000};
      load_prog();
      run_prog(20, 1'b1);
      select_mem = 7'd5; #1;
      check("wrap5", output_mem_cell, 24'hFFFFFF);

      do_reset();
      prog = '{24'h010000, 24'h100304, 24'h020207, 24'h020309, 24'h040203, 24'h000000};
      load_prog();
      run_prog(20, 1'b1);
      select_mem = 7'd7; #1;
      check("bnz_fall", output_mem_cell, 24'd9);

      do_reset();
      set_fib();
      load_prog();
      run_prog(6, 1'b0);
      do_reset();
      set_fib();
      load_prog();
      run_prog(40, 1'b1);
      select_mem = 7'd40; #1;
      check("fib40_reload", output_mem_cell, 24'd3);

      do_reset();
      prog = '{24'h010000, 24'h020004, 24'h030100, 24'h090100, 24'h060601, 24'h3F1234,
               24'h0D0201, 24'h10FC00, 24'h020328, 24'h040306, 24'h000000};
      load_prog();
      run_prog(50, 1'b1);
      select_mem = 7'd40; #1;
      check("nop40", output_mem_cell, 24'd3);

      for (int t = 0; t < 8; t++) begin
         do_reset();
         gen_random($urandom_range(6, 30));
         load_prog();
         run_prog(40, 1'b1);
      end

      // 32 words with no HALT: load stops at the last slot and the PC wraps.
      do_reset();
      prog.delete();
      for (int i = 0; i < 32; i++)
         prog.push_back({8'($urandom_range(2, 4)), 8'($urandom), 8'($urandom)});
      load_prog();
      run_prog(70, 1'b0);

      do_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/microprocessor.md
Name: microprocessor

Overview:
- Small 24-bit load-then-run processor.
- After reset it captures a program from `instruction_input`, one word per clock, into instruction memory until it captures a HALT word.
- It then executes the program one instruction per clock over an 8-entry register file and a 128-word data memory.
- `select_mem` provides a combinational window into data memory; `program_done_flag` signals that HALT has executed.

Parameters:
- IMEM_AW, 5, instruction memory address width (32 words, PC wraps modulo 32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction_input  input  24  program word captured each cycle in LOAD state.
- select_mem  input  7  data memory address to observe.
- output_mem_cell  output  24  combinational `dmem[select_mem]`.
- program_done_flag  output  1  high while in DONE state.

Behaviour:
- Instruction format: op = [23:16], A = [15:8], B = [7:0].
  - Register index = low 3 bits of the field.
  - Data address = low 7 bits of the register value.
- Reset (`reset`=0, asynchronous) clears:
  - state to LOAD, load pointer and PC to 0;
  - all registers r0..r7 and all 128 data words to 0;
  - `program_done_flag` to 0, so `output_mem_cell` reads 0.
  - Instruction memory is not cleared.
- LOAD state, each posedge: `imem[ptr] <= instruction_input`, then `ptr++`.
  - If the captured word is 24'h000000, or `ptr` is 31, go to RUN with PC=0. The HALT word itself is stored.
- RUN state: fetch `imem[PC]`, execute, update the destination in the same edge, PC+1 unless a branch is taken. Latency is one clock per instruction.
- Opcodes:
  - 0x00 HALT: go to DONE; PC holds.
  - 0x01 CLR: all registers <= 0.
  - 0x02 LDI: `R[A] <= {16'b0, B}`.
  - 0x03 INC: `R[A] <= R[A] + 1`.
  - 0x04 STORE: `dmem[R[A][6:0]] <= R[B]`.
  - 0x06 MOV: `R[A] <= R[B]`.
  - 0x09 SUBI: `R[B] <= R[B] - A` (A unsigned).
  - 0x0D XADD: `R[A] <= R[B]`; `R[B] <= R[A] + R[B]`. Both use old values; if A==B, the sum wins.
  - 0x10 BNZ: if `R[B] != 0` then `PC <= PC + sext(A)`, else `PC+1`.
  - All other opcodes are NOPs.
- Arithmetic: 24-bit, wraps modulo 2^24, no flags. PC arithmetic wraps modulo 32.
- DONE state: holds all state; `program_done_flag`=1 until reset.
- `output_mem_cell` is valid in every state, including during RUN; a STORE becomes visible after its clock edge.
- Reset asserted mid-load or mid-run aborts immediately and returns to LOAD.

Optional Feature:
- Macro MICROPROCESSOR_LOAD_OP_EN.
- Defined: opcode 0x0A LOAD, `R[A] <= dmem[R[B][6:0]]`.
- Undefined: 0x0A is a NOP and the data memory has no internal read port beyond `output_mem_cell`.

Test Plan:
- Reset held low -> `program_done_flag`=0; `output_mem_cell`=0 for `select_mem`=0, 40, 127.
- Fibonacci program, `select_mem`=40: load in order
  - 010000, 020004, 030100, 090100, 060601, 0D0201, 10FD00, 020328, 040306, 000000
  - -> after ≤40 run cycles, `program_done_flag`=1 and `output_mem_cell`=3.
- Wrap: load LDI r1,0 / SUBI r1,1 / STORE via r2=5 (r2 set by LDI) / HALT -> `dmem[5]`=24'hFFFFFF.
- Branch not taken: BNZ on a zero register falls through; the following STORE executes and HALT asserts the flag.
- Reset pulsed low during RUN -> flag 0, `dmem` reads 0; reloading the Fibonacci program again yields 3 at address 40.
- Unknown opcode 0x3F mid-program -> no state change; the program result is unchanged.
